// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the sequential neuron layer.
// PLAN sigmoid constants are kept in 1/32 units and scaled by the user.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_OUTPUT
  } state_t;

  localparam int unsigned Q5_FRAC    = 5;
  localparam int unsigned BP_HI_Q5   = 160;
  localparam int unsigned BP_MID_Q5  = 76;
  localparam int unsigned BP_LO_Q5   = 32;
  localparam int unsigned OFF_HI_Q5  = 27;
  localparam int unsigned OFF_MID_Q5 = 20;
  localparam int unsigned OFF_LO_Q5  = 16;

  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        w
  );
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    if (s > hi) return hi[63:0];
    if (s < lo) return lo[63:0];
    return s[63:0];
  endfunction

endpackage

// File: rtl/neuron_layer_seq_sigmoid_pwl.sv
// Combinational PLAN sigmoid: signed fixed-point in, unsigned [0,1] out.
module sigmoid_pwl
  import nn_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int FRAC_W = 16
) (
  input  logic signed [ACC_W-1:0] x,
  output logic        [ACC_W-1:0] y
);

  localparam int SH = FRAC_W - Q5_FRAC;
  localparam logic [ACC_W-1:0] ONE     = ACC_W'(1) << FRAC_W;
  localparam logic [ACC_W-1:0] BP_HI   = ACC_W'(BP_HI_Q5) << SH;
  localparam logic [ACC_W-1:0] BP_MID  = ACC_W'(BP_MID_Q5) << SH;
  localparam logic [ACC_W-1:0] BP_LO   = ACC_W'(BP_LO_Q5) << SH;
  localparam logic [ACC_W-1:0] OFF_HI  = ACC_W'(OFF_HI_Q5) << SH;
  localparam logic [ACC_W-1:0] OFF_MID = ACC_W'(OFF_MID_Q5) << SH;
  localparam logic [ACC_W-1:0] OFF_LO  = ACC_W'(OFF_LO_Q5) << SH;

  logic             neg;
  logic [ACC_W-1:0] a;
  logic [ACC_W-1:0] yp;
  logic             r_hi;
  logic             r_mid;
  logic             r_lo;

  // The most-negative input negates to itself, lands in r_hi and yields 0.
  assign neg   = x[ACC_W-1];
  assign a     = neg ? ACC_W'(-x) : ACC_W'(x);
  assign r_hi  = a >= BP_HI;
  assign r_mid = !r_hi && (a >= BP_MID);
  assign r_lo  = !r_hi && !r_mid && (a >= BP_LO);

  always_comb begin
    yp = (a >> 2) + OFF_LO;
    unique case (1'b1)
      r_hi:    yp = ONE;
      r_mid:   yp = (a >> 5) + OFF_HI;
      r_lo:    yp = (a >> 3) + OFF_MID;
      default: yp = (a >> 2) + OFF_LO;
    endcase
  end

  assign y = neg ? ONE - yp : yp;

endmodule

// File: rtl/neuron_layer_seq.sv
// Time-multiplexed fully-connected layer: one MAC, PLAN sigmoid output.
// Define NEURON_BIAS_EN to add per-neuron bias registers.
module neuron_layer_seq
  import nn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int FRAC_W = 16,
  parameter int N_IN   = 5,
  parameter int N_OUT  = 4,
  localparam int NW    = N_OUT * N_IN,
  localparam int AW    = $clog2(N_OUT * (N_IN + 1)),
  localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int CW    = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_we,
  input  logic [AW-1:0]     w_addr,
  input  logic [ACC_W-1:0]  w_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [IW-1:0]     out_idx,
  output logic              out_last
);

  state_t state;
  state_t state_nx;

  logic        [CW-1:0]     i;
  logic        [IW-1:0]     j;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] x_buf [N_IN];
  logic signed [DATA_W-1:0] w_mem [NW];

  logic                       i_last;
  logic                       j_last;
  logic                       w_ok;
  logic        [AW-1:0]       w_rd;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [63:0]         acc_w;
  logic signed [63:0]         prod_w;
  logic signed [63:0]         sum_w;
  logic signed [ACC_W-1:0]    acc_sum;
  logic        [ACC_W-1:0]    sig_y;
  logic signed [ACC_W-1:0]    init_first;
  logic signed [ACC_W-1:0]    init_next;

  assign i_last   = i == CW'(N_IN - 1);
  assign j_last   = j == IW'(N_OUT - 1);
  assign in_ready = state == ST_LOAD;
  assign w_ok     = w_we && (state == ST_LOAD);

  assign w_rd    = AW'(j) * AW'(N_IN) + AW'(i);
  assign prod    = x_buf[i] * w_mem[w_rd];
  assign acc_w   = {{(64 - ACC_W){acc[ACC_W-1]}}, acc};
  assign prod_w  = {{(64 - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
  assign sum_w   = sat_add(acc_w, prod_w, ACC_W);
  assign acc_sum = sum_w[ACC_W-1:0];

  sigmoid_pwl #(
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W)
  ) u_sig (
    .x (acc_sum),
    .y (sig_y)
  );

`ifdef NEURON_BIAS_EN
  logic signed [ACC_W-1:0] bias [N_OUT];
  logic        [IW-1:0]    j_inc;
  logic        [AW-1:0]    b_off;

  assign j_inc      = j + 1'b1;
  assign b_off      = w_addr - AW'(NW);
  assign init_first = bias[0];
  assign init_next  = bias[j_inc];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) bias[k] <= '0;
    end else if (w_ok && (w_addr >= AW'(NW))
                 && (b_off < AW'(N_OUT))) begin
      bias[IW'(b_off)] <= w_data;
    end
  end
`else
  assign init_first = '0;
  assign init_next  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_LOAD:
        if (in_valid && i_last) state_nx = ST_COMPUTE;
      ST_COMPUTE:
        if (i_last) state_nx = ST_OUTPUT;
      ST_OUTPUT:
        if (out_ready) state_nx = j_last ? ST_LOAD : ST_COMPUTE;
      default:
        state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) w_mem[k] <= '0;
    end else if (w_ok && (w_addr < AW'(NW))) begin
      w_mem[w_addr] <= w_data[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i         <= '0;
      j         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      for (int k = 0; k < N_IN; k++) x_buf[k] <= '0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (in_valid) begin
            x_buf[i] <= in_data;
            if (i_last) begin
              i   <= '0;
              j   <= '0;
              acc <= init_first;
            end else begin
              i <= i + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          acc <= acc_sum;
          if (i_last) begin
            i         <= '0;
            out_data  <= sig_y;
            out_idx   <= j;
            out_valid <= 1'b1;
            out_last  <= j_last;
          end else begin
            i <= i + 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            i         <= '0;
            if (!j_last) begin
              j   <= j + 1'b1;
              acc <= init_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
